cpu_state_checker: RTL and testbench

Synthesizable end-of-program checker for the single-cycle CPU labs: watches the fetched instruction stream for a halt word, freezes the core, then walks PC, data memory and register file through read ports and compares each word against an expected-results ROM. It replaces the bench-only halt/compare loop with a parametrised block usable on FPGA and in simulation, adding a watchdog timeout, saturating error count and first-failure index.

---
 rtl/cpu_checker_pkg.sv | 25 ++
 rtl/cpu_checker_watchdog.sv | 28 ++
 rtl/cpu_state_checker.sv | 188 ++++++++++++++++++
 tb/tb_cpu_state_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_checker_pkg.sv
// cpu_checker_pkg: shared FSM state encoding and expected-ROM region layout for the
// CPU end-of-program checkers.
package cpu_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } chk_state_t;

  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
  localparam int          PC_IDX             = 0;

  // ROM order is PC, then data memory, then the register file.
  function automatic int mem_base();
    return PC_IDX + 1;
  endfunction

  function automatic int reg_base(input int mem_words);
    return mem_base() + mem_words;
  endfunction

endpackage

// File: rtl/cpu_checker_watchdog.sv
// cpu_checker_watchdog: loadable cycle counter that raises expired_o on the LIMIT-th
// enabled cycle after a load.
module cpu_checker_watchdog #(
  parameter int LIMIT = 200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      count <= '0;
    end else if (en_i && !expired_o) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_o = en_i && (count == LAST);

endmodule

// File: rtl/cpu_state_checker.sv
// cpu_state_checker: freezes the core on the halt word, then compares PC, data memory and
// registers with an expected-results ROM. Optional mismatch log: CPU_STATE_CHECKER_ERR_LOG_EN.
module cpu_state_checker
  import cpu_checker_pkg::*;
#(
  parameter int                  DATA_W         = 32,
  parameter int                  MEM_WORDS      = 32,
  parameter int                  REG_NUM        = 32,
  parameter logic [DATA_W-1:0]   HALT_INSTR     = DATA_W'(DEFAULT_HALT_INSTR),
  parameter int                  TIMEOUT_CYCLES = 200,
  parameter int                  ERR_W          = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          start_i,
  input  logic [DATA_W-1:0]                             instr_i,
  input  logic [DATA_W-1:0]                             pc_i,
  output logic                                          freeze_o,
  output logic [$clog2(1+MEM_WORDS+REG_NUM)-1:0]        exp_addr_o,
  input  logic [DATA_W-1:0]                             exp_data_i,
  output logic [((MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1)-1:0] mem_addr_o,
  input  logic [DATA_W-1:0]                             mem_data_i,
  output logic [((REG_NUM > 1) ? $clog2(REG_NUM) : 1)-1:0]     reg_addr_o,
  input  logic [DATA_W-1:0]                             reg_data_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          pass_o,
  output logic                                          timeout_o,
  output logic [ERR_W-1:0]                              err_count_o,
  output logic [$clog2(1+MEM_WORDS+REG_NUM)-1:0]        first_err_idx_o
`ifdef CPU_STATE_CHECKER_ERR_LOG_EN
  ,
  output logic                                          err_valid_o,
  output logic [$clog2(1+MEM_WORDS+REG_NUM)-1:0]        err_idx_o,
  output logic [DATA_W-1:0]                             err_exp_o,
  output logic [DATA_W-1:0]                             err_got_o
`endif
);

  localparam int N      = 1 + MEM_WORDS + REG_NUM;
  localparam int IDX_W  = $clog2(N);
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int REG_AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  localparam logic [IDX_W-1:0] PC_IDX_I   = IDX_W'(PC_IDX);
  localparam logic [IDX_W-1:0] MEM_BASE_I = IDX_W'(mem_base());
  localparam logic [IDX_W-1:0] REG_BASE_I = IDX_W'(reg_base(MEM_WORDS));
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  chk_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [DATA_W-1:0] pc_snap;
  logic [DATA_W-1:0] got;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;
  logic              wd_load;
  logic              wd_en;
  logic              wd_expired;

  assign wd_load = start_i && (state == ST_IDLE || state == ST_DONE);
  assign wd_en   = (state == ST_RUN);

  cpu_checker_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (wd_load),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    got = reg_data_i;
    if (idx == PC_IDX_I) begin
      got = pc_snap;
    end else if (idx < REG_BASE_I) begin
      got = mem_data_i;
    end
    mismatch = (state == ST_CHECK) && (got != exp_data_i);
    err_next = err_count_o;
    if (mismatch && (err_count_o != ERR_MAX)) begin
      err_next = err_count_o + ERR_W'(1);
    end
    idx_next = idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      idx             <= '0;
      pc_snap         <= '0;
      freeze_o        <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      timeout_o       <= 1'b0;
      err_count_o     <= '0;
      first_err_idx_o <= '1;
      exp_addr_o      <= '0;
      mem_addr_o      <= '0;
      reg_addr_o      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state           <= ST_RUN;
            idx             <= '0;
            freeze_o        <= 1'b0;
            busy_o          <= 1'b1;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            timeout_o       <= 1'b0;
            err_count_o     <= '0;
            first_err_idx_o <= '1;
            exp_addr_o      <= '0;
            mem_addr_o      <= '0;
            reg_addr_o      <= '0;
          end
        end
        // Halt is tested first so it wins when it lands on the expiry edge.
        ST_RUN: begin
          if (instr_i == HALT_INSTR) begin
            state      <= ST_DRAIN;
            freeze_o   <= 1'b1;
            exp_addr_o <= '0;
          end else if (wd_expired) begin
            state     <= ST_DONE;
            freeze_o  <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            pass_o    <= 1'b0;
            timeout_o <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state      <= ST_CHECK;
          pc_snap    <= pc_i;
          idx        <= '0;
          exp_addr_o <= IDX_W'(1);
        end
        // Addresses run one index ahead because the ROM has a cycle of latency.
        ST_CHECK: begin
          err_count_o <= err_next;
          if (mismatch && (err_count_o == '0)) begin
            first_err_idx_o <= idx;
          end
          if (idx == LAST_IDX) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_next == '0);
          end else begin
            idx        <= idx_next;
            exp_addr_o <= idx_next + IDX_W'(1);
            if (idx_next < REG_BASE_I) begin
              mem_addr_o <= MEM_AW'(idx_next - MEM_BASE_I);
            end else begin
              reg_addr_o <= REG_AW'(idx_next - REG_BASE_I);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CPU_STATE_CHECKER_ERR_LOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_idx_o   <= '0;
      err_exp_o   <= '0;
      err_got_o   <= '0;
    end else begin
      err_valid_o <= mismatch;
      if (mismatch) begin
        err_idx_o <= idx;
        err_exp_o <= exp_data_i;
        err_got_o <= got;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_state_checker.sv
// Testbench for cpu_state_checker (ERR_W=2 so saturation is reachable); define
// CPU_STATE_CHECKER_ERR_LOG_EN to also exercise the mismatch log ports.
`timescale 1ns/1ps
module tb_cpu_state_checker;

  localparam int MEM_WORDS = 32;
  localparam int REG_NUM   = 32;
  localparam int TIMEOUT   = 200;
  localparam int ERR_W     = 2;
  localparam int N         = 1 + MEM_WORDS + REG_NUM;
  localparam int IDX_W     = $clog2(N);
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      instr;
  logic [31:0]      pc;
  logic             freeze;
  logic [IDX_W-1:0] exp_addr;
  logic [31:0]      exp_data;
  logic [4:0]       mem_addr;
  logic [31:0]      mem_data;
  logic [4:0]       reg_addr;
  logic [31:0]      reg_data;
  logic             busy, done, pass, timeout;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] first_err_idx;
`ifdef CPU_STATE_CHECKER_ERR_LOG_EN
  logic             err_valid;
  logic [IDX_W-1:0] err_idx;
  logic [31:0]      err_exp;
  logic [31:0]      err_got;
`endif

  logic [31:0] mem  [MEM_WORDS];
  logic [31:0] regs [REG_NUM];
  logic [31:0] rom  [2**IDX_W];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          halts;
    int          halt_pc;
    logic [N-1:0] bad;
    int          exp_edges;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
    bit          exp_timeout;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  // Combinational memory/register read ports and a registered expected-results ROM.
  assign mem_data = mem[mem_addr];
  assign reg_data = regs[reg_addr];
  always @(posedge clk) exp_data <= rom[exp_addr];

  cpu_state_checker #(
    .DATA_W         (32),
    .MEM_WORDS      (MEM_WORDS),
    .REG_NUM        (REG_NUM),
    .HALT_INSTR     (HALT),
    .TIMEOUT_CYCLES (TIMEOUT),
    .ERR_W          (ERR_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .instr_i         (instr),
    .pc_i            (pc),
    .freeze_o        (freeze),
    .exp_addr_o      (exp_addr),
    .exp_data_i      (exp_data),
    .mem_addr_o      (mem_addr),
    .mem_data_i      (mem_data),
    .reg_addr_o      (reg_addr),
    .reg_data_i      (reg_data),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .timeout_o       (timeout),
    .err_count_o     (err_count),
    .first_err_idx_o (first_err_idx)
`ifdef CPU_STATE_CHECKER_ERR_LOG_EN
    ,
    .err_valid_o     (err_valid),
    .err_idx_o       (err_idx),
    .err_exp_o       (err_exp),
    .err_got_o       (err_got)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Fresh program state; entries flagged in bad disagree with the ROM. Data has bit 31
  // clear so the 0xDEADBEEF corruption can never coincide with the expected word.
  task automatic loadState(input int halt_pc, input logic [N-1:0] bad);
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    for (int i = 0; i < REG_NUM; i++) regs[i] = $urandom & 32'h7FFF_FFFF;
    rom[0] = halt_pc;
    for (int i = 0; i < MEM_WORDS; i++) rom[1 + i] = mem[i];
    for (int i = 0; i < REG_NUM; i++) rom[1 + MEM_WORDS + i] = regs[i];
    for (int i = 0; i < N; i++) begin
      if (bad[i]) begin
        if (i == 0) rom[0] = rom[0] ^ 32'h1;
        else if (i <= MEM_WORDS) mem[i - 1] = 32'hDEAD_BEEF;
        else regs[i - 1 - MEM_WORDS] = 32'hDEAD_BEEF;
      end
    end
  endtask

  function automatic logic [31:0] fetchWord(input logic [31:0] p, input bit halts, input int halt_pc);
    return (halts && p == 32'(halt_pc)) ? HALT : (p | 32'h13);
  endfunction

  // One program run from a start pulse until done_o; the core stops advancing at the halt word.
  task automatic applyStimulus(input bit halts, input int halt_pc, input logic [N-1:0] bad,
                               input bit poke_start, output int edges, output int log_pulses,
                               output int log_first, output bit rom_quiet);
    loadState(halt_pc, bad);
    pc = 0;
    instr = fetchWord(pc, halts, halt_pc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    log_pulses = 0;
    log_first = -1;
    rom_quiet = 1'b1;
    while (!done && edges < 1000) begin
      @(posedge clk); #1;
      edges++;
      if (exp_addr != '0) rom_quiet = 1'b0;
`ifdef CPU_STATE_CHECKER_ERR_LOG_EN
      if (err_valid) begin
        if (log_pulses == 0) log_first = int'(err_idx);
        log_pulses++;
      end
`endif
      if (instr != HALT) pc = pc + 4;
      instr = fetchWord(pc, halts, halt_pc);
      start = poke_start && busy && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
  endtask

  task automatic checkRun(input string tag, input vec_t v, input bit poke_start);
    int edges, pulses, log_first;
    bit quiet;
    applyStimulus(v.halts, v.halt_pc, v.bad, poke_start, edges, pulses, log_first, quiet);
    checkOutput({tag, " done_edges"}, 64'(edges), 64'(v.exp_edges));
    checkOutput({tag, " err_count"}, 64'(err_count), 64'(v.exp_err));
    checkOutput({tag, " first_err_idx"}, 64'(first_err_idx), 64'(v.exp_first));
    checkOutput({tag, " pass"}, 64'(pass), 64'(v.exp_pass));
    checkOutput({tag, " timeout"}, 64'(timeout), 64'(v.exp_timeout));
    checkOutput({tag, " busy"}, 64'(busy), 64'(0));
    if (v.exp_timeout) checkOutput({tag, " rom_quiet"}, 64'(quiet), 64'(1));
    else checkOutput({tag, " freeze"}, 64'(freeze), 64'(1));
`ifdef CPU_STATE_CHECKER_ERR_LOG_EN
    checkOutput({tag, " log_pulses"}, 64'(pulses), 64'(v.exp_timeout ? 0 : $countones(v.bad)));
    if (v.exp_first != 127) checkOutput({tag, " log_first"}, 64'(log_first), 64'(v.exp_first));
`endif
  endtask

  initial begin
    logic [N-1:0] one;
    vec_t rv;
    one = 1;

    vecs[0] = '{1'b1, 32'h20,  '0,                                            75,  0, 127, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h20,  one << 4,                                      75,  1, 4,   1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h40,  (one << 38) | (one << 1),                      83,  2, 1,   1'b0, 1'b0};
    vecs[3] = '{1'b0, 0,       '0,                                            200, 0, 127, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h10,  one | (one << 10) | (one << 20) | (one << 40) | (one << 64),
                                                                              71,  3, 0,   1'b0, 1'b0};
    vecs[5] = '{1'b1, 796,     '0,                                            266, 0, 127, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 800,     '0,                                            200, 0, 127, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    pc = '0;
    instr = '0;
    loadState(0, '0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset freeze", 64'(freeze), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset pass", 64'(pass), 64'(0));
    checkOutput("reset timeout", 64'(timeout), 64'(0));
    checkOutput("reset err_count", 64'(err_count), 64'(0));
    checkOutput("reset first_err_idx", 64'(first_err_idx), 64'(127));
    checkOutput("reset exp_addr", 64'(exp_addr), 64'(0));
    checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("reset reg_addr", 64'(reg_addr), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) checkRun($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Randomized halts and corruptions against a flat model; start_i is poked while busy.
    for (int r = 0; r < 8; r++) begin
      int k, lowest;
      rv.halts = 1'b1;
      rv.halt_pc = 4 * $urandom_range(0, 60);
      rv.bad = '0;
      k = $urandom_range(0, 5);
      for (int j = 0; j < k; j++) rv.bad[$urandom_range(0, N - 1)] = 1'b1;
      lowest = 127;
      for (int j = N - 1; j >= 0; j--) if (rv.bad[j]) lowest = j;
      rv.exp_edges = rv.halt_pc / 4 + 1 + N + 1;
      rv.exp_err = ($countones(rv.bad) > 3) ? 3 : $countones(rv.bad);
      rv.exp_first = lowest;
      rv.exp_pass = (rv.bad == '0);
      rv.exp_timeout = 1'b0;
      checkRun($sformatf("rand%0d", r), rv, 1'b1);
    end

    // Reset while checking index 10, with two mismatches already counted.
    loadState(0, (one << 1) | (one << 5));
    pc = 0;
    instr = HALT;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midcheck busy", 64'(busy), 64'(1));
    checkOutput("midcheck freeze", 64'(freeze), 64'(1));
    checkOutput("midcheck err_count", 64'(err_count), 64'(2));
    checkOutput("midcheck first_err_idx", 64'(first_err_idx), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset freeze", 64'(freeze), 64'(0));
    checkOutput("midreset busy", 64'(busy), 64'(0));
    checkOutput("midreset done", 64'(done), 64'(0));
    checkOutput("midreset err_count", 64'(err_count), 64'(0));
    checkOutput("midreset first_err_idx", 64'(first_err_idx), 64'(127));
    checkOutput("midreset exp_addr", 64'(exp_addr), 64'(0));
    @(posedge clk); #1;
    checkRun("after_reset", vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
